// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: whole-packet round-robin TLP arbiter; MRd heads gated on completion credit and a post-grant holdoff.
// Latency: 1-cycle arbitration in IDLE, then the granted slice reaches out_* combinationally (no added data latency).
// Backpressure: out_tready goes straight to the owner's req_tready; non-owners, and everyone in IDLE, see 0.
module pcie_tx_arb #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 512,
    parameter int CPL_CREDIT_WIDTH = 12,
    parameter int CPL_CREDIT_MAX   = 2048,
    parameter int MRD_HOLDOFF      = 8,
    localparam int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          fim_clk,
    input  logic                          fim_rst_n,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    input  logic [NUM_REQ-1:0]            req_tlast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]            req_is_mrd,
    input  logic [NUM_REQ*11-1:0]         req_mrd_len,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic                          out_tlast,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic [ID_W-1:0]               out_gnt_id,
    input  logic [CPL_CREDIT_WIDTH-1:0]   cpl_pending_data_cnt,
    output logic                          mrd_blocked
);

    // One bit wider than the wider addend so pending + length can never wrap.
    localparam int SUM_W = ((CPL_CREDIT_WIDTH > 11) ? CPL_CREDIT_WIDTH : 11) + 1;
    localparam int HO_W  = (MRD_HOLDOFF > 1) ? $clog2(MRD_HOLDOFF + 1) : 1;

    localparam logic [SUM_W-1:0] CREDIT_MAX   = SUM_W'(CPL_CREDIT_MAX);
    localparam logic [HO_W-1:0]  HOLDOFF_LOAD = HO_W'(MRD_HOLDOFF);
    localparam logic [ID_W-1:0]  LAST_ID      = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NREQ_W       = (ID_W + 1)'(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     rr_ptr;
    logic [HO_W-1:0]     holdoff;

    logic [SUM_W-1:0]    credit_sum [NUM_REQ];
    logic [NUM_REQ-1:0]  mrd_ok;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  mrd_skip;
    logic [ID_W:0]       cand;
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     next_rr;
    logic                busy;
    logic                pkt_done;

    // Per-requester eligibility: non-MRd needs only tvalid; MRd also needs zero holdoff and room in the completion buffer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_sum[i] = SUM_W'(cpl_pending_data_cnt) + SUM_W'(req_mrd_len[i*11 +: 11]);
            mrd_ok[i]     = (holdoff == '0) && (credit_sum[i] <= CREDIT_MAX);
            elig[i]       = req_tvalid[i] && (!req_is_mrd[i] || mrd_ok[i]);
            mrd_skip[i]   = req_tvalid[i] && req_is_mrd[i] && !mrd_ok[i];
        end
    end

    // Round-robin scan: first eligible index at or above rr_ptr, wrapping modulo NUM_REQ; blocked MRds are skipped, not waited on.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && elig[cand[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[ID_W-1:0];
            end
        end
    end

    assign next_rr  = (pick == LAST_ID) ? '0 : pick + ID_W'(1);
    assign busy     = (state == BUSY);
    assign pkt_done = out_tvalid && out_tready && out_tlast;

    // Arbitration FSM plus the holdoff counter and the registered MRd-blocked flag.
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state       <= IDLE;
            gnt_id      <= '0;
            rr_ptr      <= '0;
            holdoff     <= '0;
            mrd_blocked <= 1'b0;
        end else begin
            mrd_blocked <= (state == IDLE) && (|mrd_skip);
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= BUSY;
                        gnt_id <= pick;
                        rr_ptr <= next_rr;
                    end
                end
                BUSY: begin
                    if (pkt_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A fresh MRd grant reloads the holdoff; otherwise it counts down to zero in every state.
            if ((state == IDLE) && found && req_is_mrd[pick]) begin
                holdoff <= HOLDOFF_LOAD;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HO_W'(1);
            end
        end
    end

    // Merged stream: the owner's slice passes straight through; bubbles from the owner keep the grant.
    assign out_tvalid = busy && req_tvalid[gnt_id];
    assign out_tlast  = busy && req_tlast[gnt_id];
    assign out_tdata  = req_tdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    assign out_gnt_id = gnt_id;

    // Only the owner sees out_tready, and only while a packet is being streamed.
    always_comb begin
        req_tready = '0;
        if (busy) begin
            req_tready[gnt_id] = out_tready;
        end
    end

endmodule
